// File: rtl/ocp_wait_memory.sv
// Behavioural OCP slave memory: configurable base/size, independent read/write wait states, ERR on bad access.
// Response is registered and lasts one cycle; accept is low from accept until the response cycle ends.
module ocp_wait_memory #(
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32,
  parameter int          BEN_WIDTH  = DATA_WIDTH / 8,
  parameter int          MEMWORDS   = 65536,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          RD_LATENCY = 1,
  parameter int          WR_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [ADDR_WIDTH-1:0] i_MAddr,
  input  logic [2:0]            i_MCmd,
  input  logic [DATA_WIDTH-1:0] i_MData,
  input  logic [BEN_WIDTH-1:0]  i_MByteEn,
  output logic                  o_SCmdAccept,
  output logic [DATA_WIDTH-1:0] o_SData,
  output logic [1:0]            o_SResp
);

  localparam logic [2:0] CMD_IDLE  = 3'd0;
  localparam logic [2:0] CMD_WRITE = 3'd1;
  localparam logic [2:0] CMD_READ  = 3'd2;
  localparam logic [1:0] RESP_NULL = 2'd0;
  localparam logic [1:0] RESP_DVA  = 2'd1;
  localparam logic [1:0] RESP_ERR  = 2'd3;

  localparam int IDX_W = (MEMWORDS > 1) ? $clog2(MEMWORDS) : 1;
  localparam logic [3:0] RD_WAIT = 4'(RD_LATENCY - 1);
  localparam logic [3:0] WR_WAIT = 4'(WR_LATENCY - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH+1:0] SPAN = (ADDR_WIDTH + 2)'(MEMWORDS) << 2;
  localparam logic [DATA_WIDTH-1:0] POISON = DATA_WIDTH'(32'hDEAD_DEAD);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t                state_q, state_d;
  logic [3:0]            wait_cnt_q, wait_cnt_d;
  logic [2:0]            cmd_q, cmd_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [BEN_WIDTH-1:0]  ben_q, ben_d;
  logic [1:0]            resp_q, resp_d;
  logic [DATA_WIDTH-1:0] sdata_q, sdata_d;

  logic [DATA_WIDTH-1:0] mem [MEMWORDS];

  logic [2:0]            cur_cmd;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [DATA_WIDTH-1:0] cur_data;
  logic [BEN_WIDTH-1:0]  cur_ben;
  logic [ADDR_WIDTH-1:0] off;
  logic                  in_range;
  logic [IDX_W-1:0]      idx;
  logic                  enter_resp;
  logic                  mem_we;

  // With a one-cycle latency the response is built straight from the bus inputs.
  always_comb begin
    cur_cmd  = cmd_q;
    cur_addr = addr_q;
    cur_data = data_q;
    cur_ben  = ben_q;
    if (state_q == ST_IDLE) begin
      cur_cmd  = i_MCmd;
      cur_addr = i_MAddr;
      cur_data = i_MData;
      cur_ben  = i_MByteEn;
    end
  end

  assign off      = cur_addr - BASE;
  assign in_range = (cur_addr >= BASE) && ({2'b00, off} < SPAN);
  assign idx      = off[IDX_W+1:2];

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    data_d     = data_q;
    ben_d      = ben_q;
    resp_d     = RESP_NULL;
    sdata_d    = sdata_q;
    enter_resp = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_MCmd != CMD_IDLE) begin
          cmd_d      = i_MCmd;
          addr_d     = i_MAddr;
          data_d     = i_MData;
          ben_d      = i_MByteEn;
          wait_cnt_d = (i_MCmd == CMD_READ) ? RD_WAIT : WR_WAIT;
          if (wait_cnt_d == 4'd0) begin
            enter_resp = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        wait_cnt_d = wait_cnt_q - 4'd1;
        if (wait_cnt_q <= 4'd1) begin
          enter_resp = 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (enter_resp) begin
      state_d = ST_RESP;
      resp_d  = RESP_ERR;
      sdata_d = '0;
      if (cur_cmd == CMD_READ) begin
        if (in_range) begin
          resp_d  = RESP_DVA;
          sdata_d = mem[idx];
        end else begin
          sdata_d = POISON;
        end
      end else if ((cur_cmd == CMD_WRITE) && in_range) begin
        resp_d = RESP_DVA;
      end
    end
  end

  // Reset must never let a write land, even if a command is presented during it.
  assign mem_we = nrst && enter_resp && (cur_cmd == CMD_WRITE) && in_range;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < BEN_WIDTH; b++) begin
        if (cur_ben[b]) begin
          mem[idx][8*b +: 8] <= cur_data[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= 4'd0;
      cmd_q      <= CMD_IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      ben_q      <= '0;
      resp_q     <= RESP_NULL;
      sdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      ben_q      <= ben_d;
      resp_q     <= resp_d;
      sdata_q    <= sdata_d;
    end
  end

  assign o_SCmdAccept = (state_q == ST_IDLE);
  assign o_SResp      = resp_q;
  assign o_SData      = sdata_q;

endmodule
